piezo_phase_scheduler: RTL

PIEZO_PHASE_SCHEDULER -- requirements
Module: piezo_phase_scheduler

---
 rtl/piezo_phase_scheduler_if.sv | 25 ++
 rtl/piezo_phase_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/piezo_phase_scheduler_if.sv
// Register bus for the piezo phase scheduler: single-cycle writes with no wait
// states, and reads that return data on the cycle after the strobe.
interface piezo_phase_scheduler_if;
  logic [6:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/piezo_phase_scheduler.sv
// Piezo phase scheduler: a shared period counter drives NUM_CH square waves.
// Each wave is offset by its own phase. Software writes phases into a shadow
// table. A commit copies the shadow table into the active table, and the copy
// waits for a period boundary whenever the drive is enabled.
module piezo_phase_scheduler #(
  parameter int NUM_CH  = 89,
  parameter int PERIOD  = 1250,
  parameter int PHASE_W = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  piezo_phase_scheduler_if.slave avs,
  output logic [NUM_CH-1:0]      piezo_out,
  output logic                   piezo_enable,
  output logic [2:0]             piezo_status
);

  localparam logic [6:0]       CTRL_ADDR = 7'h60;
  localparam logic [6:0]       STAT_ADDR = 7'h61;
  localparam logic [PHASE_W-1:0] CNT_LAST = PHASE_W'(PERIOD - 1);
  localparam logic [PHASE_W:0] PER_EXT  = (PHASE_W + 1)'(PERIOD);
  localparam logic [PHASE_W:0] HALF_EXT = (PHASE_W + 1)'(PERIOD / 2);

  // Register state
  logic [PHASE_W-1:0] cnt_q, cnt_d;
  logic               en_q, en_d;
  logic               pend_q, pend_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [NUM_CH-1:0]  out_q, out_d;
  logic [PHASE_W-1:0] shadow_q [NUM_CH];
  logic [PHASE_W-1:0] active_q [NUM_CH];

  // Bus decode
  logic [6:0]         addr;
  logic [PHASE_W-1:0] wdata_ph;
  logic               addr_is_ph;
  logic               ph_ok;
  logic               wr_phase;
  logic               wr_ctrl;
  logic               commit_wr;
  logic               err_clr;
  logic               err_set;
  logic               wrap;
  logic               copy;
  logic [31:0]        stat_word;
  logic               unused_wdata;

  assign addr       = avs.avs_address;
  assign wdata_ph   = avs.avs_writedata[PHASE_W-1:0];
  assign addr_is_ph = (32'(addr) < NUM_CH);
  assign ph_ok      = (32'(wdata_ph) < PERIOD);
  assign wr_phase   = avs.avs_write && addr_is_ph;
  assign wr_ctrl    = avs.avs_write && (addr == CTRL_ADDR);
  assign commit_wr  = wr_ctrl && avs.avs_writedata[1];
  assign err_clr    = wr_ctrl && avs.avs_writedata[2];
  assign err_set    = wr_phase && !ph_ok;

  // Only the low phase bits and the three control bits carry meaning.
  assign unused_wdata = ^avs.avs_writedata[31:PHASE_W];

  assign piezo_out     = out_q;
  assign piezo_enable  = en_q;
  assign piezo_status  = {err_q, pend_q, en_q};
  assign avs.avs_readdata = rdata_q;

  // Next-state for the counter, enable, commit and error flags
  always_comb begin
    en_d = en_q;
    if (wr_ctrl) begin
      en_d = avs.avs_writedata[0];
    end

    // A wrap is a real period boundary: the drive stays enabled across it.
    wrap = en_q && en_d && (cnt_q == CNT_LAST);

    // While disabled there is no boundary to wait for, so a pending commit
    // is applied at once.
    copy = pend_q && (en_q ? wrap : 1'b1);

    // Clearing enable sends the counter straight back to 0.
    if (!en_q || !en_d) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // A commit written while one is pending merges with it. If the pending
    // commit is consumed in this cycle, the new write is absorbed.
    if (copy) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q | commit_wr;
    end

    // Setting the error outranks clearing it.
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // STATUS word: flags in the low bits, the live counter at bit 16
  always_comb begin
    stat_word = '0;
    stat_word[2:0] = piezo_status;
    stat_word[16 +: PHASE_W] = cnt_q;
  end

  // Read mux; a read is captured so that it appears on the following cycle
  always_comb begin
    rdata_d = rdata_q;
    if (avs.avs_read) begin
      if (addr_is_ph) begin
        rdata_d = 32'(shadow_q[addr]);
      end else if (addr == CTRL_ADDR) begin
        rdata_d = 32'(en_q);
      end else if (addr == STAT_ADDR) begin
        rdata_d = stat_word;
      end else begin
        rdata_d = '0;
      end
    end
  end

  // Per-channel drive: high during the half period that starts at the
  // channel's phase. The output is gated on enable both now and next, so it
  // drops together with the counter when the drive is switched off.
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [PHASE_W:0] diff;
    assign diff = (cnt_q >= active_q[n])
                ? ({1'b0, cnt_q} - {1'b0, active_q[n]})
                : ({1'b0, cnt_q} + PER_EXT - {1'b0, active_q[n]});
    assign out_d[n] = en_q && en_d && (diff < HALF_EXT);
  end

  // State registers, shadow and active phase tables
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      out_q   <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        shadow_q[n] <= '0;
        active_q[n] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
      if (wr_phase && ph_ok) begin
        shadow_q[addr] <= wdata_ph;
      end
      // Non-blocking copy picks up the shadow value from before any write
      // that lands in this same cycle.
      if (copy) begin
        for (int n = 0; n < NUM_CH; n++) begin
          active_q[n] <= shadow_q[n];
        end
      end
    end
  end

endmodule
